// File: rtl/snake_pkg.sv
// snake_pkg: shared playfield defaults and the food placer FSM state type.
// Contents: GRID_CELLS, MAX_TRIES, FOOD_INIT, BAR_INIT defaults; state_t enum.
package snake_pkg;
    localparam int GRID_CELLS = 100;
    localparam int MAX_TRIES  = 16;
    localparam int FOOD_INIT  = 55;
    localparam int BAR_INIT   = 56;
    typedef enum logic [1:0] {IDLE, PICK_FOOD, PICK_BAR} state_t;
endpackage

// File: rtl/food_placer_if.sv
// food_placer_if: bundle between the game controller (master) and the food placer (slave).
// Signals: rand_num/rand_bar random candidates, occupied snake bitmap, head_pos head cell,
//          respawn request; food_pos/bar_pos placed cells, busy, done pulse, fail pulse.
interface food_placer_if #(
    parameter int GRID_CELLS = snake_pkg::GRID_CELLS
);
    logic [7:0]            rand_num;
    logic [7:0]            rand_bar;
    logic [GRID_CELLS-1:0] occupied;
    logic [7:0]            head_pos;
    logic                  respawn;
    logic [7:0]            food_pos;
    logic [7:0]            bar_pos;
    logic                  busy;
    logic                  done;
    logic                  fail;
    modport master (
        output rand_num, rand_bar, occupied, head_pos, respawn,
        input  food_pos, bar_pos, busy, done, fail
    );
    modport slave (
        input  rand_num, rand_bar, occupied, head_pos, respawn,
        output food_pos, bar_pos, busy, done, fail
    );
endinterface

// File: rtl/cell_check.sv
// cell_check: combinational legality test for one candidate cell.
// Ports: cand candidate index, occupied snake bitmap, exclude_a/exclude_b forbidden cells,
//        ok high when the candidate is in range, free and not excluded.
module cell_check #(
    parameter int GRID_CELLS = snake_pkg::GRID_CELLS
) (
    input  logic [7:0]            cand,
    input  logic [GRID_CELLS-1:0] occupied,
    input  logic [7:0]            exclude_a,
    input  logic [7:0]            exclude_b,
    output logic                  ok
);
    localparam int IW = $clog2(GRID_CELLS);
    logic          in_range;
    logic [IW-1:0] idx;
    assign in_range = {24'd0, cand} < 32'(GRID_CELLS);
    // Out-of-range candidates are steered to cell 0 so the bitmap is never over-indexed.
    assign idx = in_range ? IW'(cand) : '0;
    assign ok  = in_range && !occupied[idx] && cand != exclude_a && cand != exclude_b;
endmodule

// File: rtl/food_placer.sv
// food_placer: places a new food cell then a barrier cell after each respawn request,
// retrying random candidates up to MAX_TRIES times per item before keeping the old cell.
// Ports: clk, rst_n (async, active-low), bus (food_placer_if.slave) carrying candidates,
//        occupied bitmap, head_pos, respawn in; food_pos, bar_pos, busy, done, fail out.
module food_placer #(
    parameter int GRID_CELLS = snake_pkg::GRID_CELLS,
    parameter int MAX_TRIES  = snake_pkg::MAX_TRIES,
    parameter int FOOD_INIT  = snake_pkg::FOOD_INIT,
    parameter int BAR_INIT   = snake_pkg::BAR_INIT
) (
    input logic         clk,
    input logic         rst_n,
    food_placer_if.slave bus
);
    import snake_pkg::*;
    localparam int CW = $clog2(MAX_TRIES + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_TRIES - 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic          fail_flag;
    logic          armed;
    logic          food_ok;
    logic          bar_ok;
    logic          last;
    cell_check #(.GRID_CELLS(GRID_CELLS)) u_food_chk (
        .cand(bus.rand_num), .occupied(bus.occupied),
        .exclude_a(bus.bar_pos), .exclude_b(bus.head_pos), .ok(food_ok)
    );
    // In PICK_BAR food_pos already holds the freshly placed food.
    cell_check #(.GRID_CELLS(GRID_CELLS)) u_bar_chk (
        .cand(bus.rand_bar), .occupied(bus.occupied),
        .exclude_a(bus.food_pos), .exclude_b(bus.head_pos), .ok(bar_ok)
    );
    assign last     = cnt == LAST;
    assign bus.busy = state != IDLE;
    // armed stays low through the first edge after reset release so a respawn
    // coincident with that edge is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            fail_flag    <= 1'b0;
            armed        <= 1'b0;
            bus.food_pos <= 8'(FOOD_INIT);
            bus.bar_pos  <= 8'(BAR_INIT);
            bus.done     <= 1'b0;
            bus.fail     <= 1'b0;
        end else begin
            armed    <= 1'b1;
            bus.done <= 1'b0;
            bus.fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.respawn && armed) begin
                        state <= PICK_FOOD;
                        cnt   <= '0;
                    end
                end
                PICK_FOOD: begin
                    if (food_ok || last) begin
                        if (food_ok) bus.food_pos <= bus.rand_num;
                        else fail_flag <= 1'b1;
                        cnt   <= '0;
                        state <= PICK_BAR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PICK_BAR: begin
                    if (bar_ok || last) begin
                        if (bar_ok) bus.bar_pos <= bus.rand_bar;
                        bus.done  <= 1'b1;
                        bus.fail  <= fail_flag | ~bar_ok;
                        fail_flag <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
